// File: rtl/sort_completion_monitor.sv
// sort_completion_monitor
// Watches the bubble-sort array and the pipeline stall/flush flags of the
// RISC-V core. Once armed by start_i, it reports when the array has been
// sorted and unchanged for STABLE_CYCLES consecutive cycles. It also counts
// cycles, stalls and flushes, and flags a timeout if the cycle budget runs out.
// Optional build macro: SORT_SIGNED_CMP_EN selects two's complement element
// comparison. The default build uses unsigned comparison.
module sort_completion_monitor #(
  parameter int N_ELEM         = 8,
  parameter int ELEM_W         = 64,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [N_ELEM*ELEM_W-1:0] elements_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     timeout_o,
  output logic                     sorted_o,
  output logic [CNT_W-1:0]         cycle_count_o,
  output logic [CNT_W-1:0]         stall_count_o,
  output logic [CNT_W-1:0]         flush_count_o,
  output logic [CNT_W-1:0]         first_sorted_cycle_o
);

  localparam int          SW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_L = SW'(STABLE_CYCLES);
  localparam logic [63:0] TIMEOUT_L = 64'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    SETTLE  = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic                       sorted_q;
  logic [N_ELEM*ELEM_W-1:0]   prevElements_q;
  logic [CNT_W-1:0]           cycleCount_q, cycleCount_d;
  logic [CNT_W-1:0]           stallCount_q, stallCount_d;
  logic [CNT_W-1:0]           flushCount_q, flushCount_d;
  logic [CNT_W-1:0]           firstSorted_q, firstSorted_d;
  logic [SW-1:0]              stableCount_q, stableCount_d;
  logic                       done_q, done_d;
  logic                       timeout_q, timeout_d;

  logic                       sortedNow;
  logic                       changed;
  logic                       timeoutHit;
  logic [SW-1:0]              stableInc;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Combinational non-decreasing test across neighbouring elements; equal values pass.
  always_comb begin
    sortedNow = 1'b1;
    for (int k = 0; k < N_ELEM - 1; k++) begin
`ifdef SORT_SIGNED_CMP_EN
      if ($signed(elements_i[k*ELEM_W +: ELEM_W]) > $signed(elements_i[(k+1)*ELEM_W +: ELEM_W]))
        sortedNow = 1'b0;
`else
      if (elements_i[k*ELEM_W +: ELEM_W] > elements_i[(k+1)*ELEM_W +: ELEM_W])
        sortedNow = 1'b0;
`endif
    end
  end

  assign changed    = (elements_i != prevElements_q);
  assign timeoutHit = ((64'(cycleCount_q) + 64'd1) >= TIMEOUT_L);
  assign stableInc  = stableCount_q + SW'(1);

  // Next-state logic: start re-arms everything; otherwise count while active and track stability.
  always_comb begin
    state_d       = state_q;
    cycleCount_d  = cycleCount_q;
    stallCount_d  = stallCount_q;
    flushCount_d  = flushCount_q;
    firstSorted_d = firstSorted_q;
    stableCount_d = stableCount_q;
    done_d        = done_q;
    timeout_d     = timeout_q;

    if (start_i) begin
      state_d       = RUN;
      cycleCount_d  = '0;
      stallCount_d  = '0;
      flushCount_d  = '0;
      firstSorted_d = '0;
      stableCount_d = '0;
      done_d        = 1'b0;
      timeout_d     = 1'b0;
    end else if ((state_q == RUN) || (state_q == SETTLE)) begin
      cycleCount_d = satInc(cycleCount_q, 1'b1);
      stallCount_d = satInc(stallCount_q, stall_i);
      flushCount_d = satInc(flushCount_q, flush_i);

      if (state_q == RUN) begin
        if (sorted_q && !changed) begin
          state_d       = SETTLE;
          stableCount_d = SW'(1);
          firstSorted_d = satInc(cycleCount_q, 1'b1);
          if (STABLE_CYCLES == 1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end else begin
        if (!sorted_q || changed) begin
          state_d       = RUN;
          stableCount_d = '0;
        end else begin
          stableCount_d = stableInc;
          if (stableInc == STABLE_L) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      if (timeoutHit) begin
        state_d   = TIMEOUT;
        timeout_d = 1'b1;
        done_d    = 1'b0;
      end
    end
  end

  // State, counters and the element snapshot; sorted and snapshot update in every state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      sorted_q       <= 1'b0;
      prevElements_q <= '0;
      cycleCount_q   <= '0;
      stallCount_q   <= '0;
      flushCount_q   <= '0;
      firstSorted_q  <= '0;
      stableCount_q  <= '0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sorted_q       <= sortedNow;
      prevElements_q <= elements_i;
      cycleCount_q   <= cycleCount_d;
      stallCount_q   <= stallCount_d;
      flushCount_q   <= flushCount_d;
      firstSorted_q  <= firstSorted_d;
      stableCount_q  <= stableCount_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
    end
  end

  assign busy_o               = (state_q == RUN) || (state_q == SETTLE);
  assign done_o               = done_q;
  assign timeout_o            = timeout_q;
  assign sorted_o             = sorted_q;
  assign cycle_count_o        = cycleCount_q;
  assign stall_count_o        = stallCount_q;
  assign flush_count_o        = flushCount_q;
  assign first_sorted_cycle_o = firstSorted_q;

endmodule
